// File: rtl/avr_bus_bridge.sv
// avr_bus_bridge: AVR XMEM host-bus bridge.
// Synchronises the AVR pins into the clk domain and latches the address.
// Decodes NCH base/mask windows and issues one-cycle write and read strobes.
// Returns registered read data to the pad and drives the pad output enable.
// Optional feature macro: SOFT_RESET_EN enables the keyed soft-reset pulse generator.
module avr_bus_bridge #(
  parameter int              AW       = 16,
  parameter int              DW       = 8,
  parameter int              NCH      = 4,
  parameter logic [NCH*AW-1:0] CH_BASE = {16'h4000, 16'hF040, 16'hF020, 16'hF000},
  parameter logic [NCH*AW-1:0] CH_MASK = {16'hC000, 16'hFFF8, 16'hFFFF, 16'hFFF0},
  parameter logic [DW-1:0]   DEF_RD   = 8'h7B,
  parameter                  SRST_ADR = 16'hF001,
  parameter                  SRST_KEY = 8'h5A,
  parameter int              SRST_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     ad,
  input  logic [AW-DW-1:0]  a,
  input  logic              ale,
  input  logic              wd,
  input  logic              rd,
  output logic [DW-1:0]     d,
  output logic              oen,
  output logic [AW-1:0]     bus_adr,
  output logic [DW-1:0]     bus_wdata,
  output logic [NCH-1:0]    ch_wr,
  output logic [NCH-1:0]    ch_rd,
  input  logic [NCH*DW-1:0] ch_rdata,
  output logic              proto_err,
  output logic              soft_rst
);

  typedef enum logic [2:0] {IDLE, ADR, WR, WHOLD, RD, RHOLD} state_t;

  state_t state, state_next;

  logic              ale_m, ale_s;
  logic              wd_m, wd_s, wd_d;
  logic              rd_m, rd_s, rd_d;
  logic [DW-1:0]     ad_m, ad_s;
  logic [AW-DW-1:0]  a_m, a_s;
  logic [NCH-1:0]    sel, sel_c;
  logic              hit;
  logic              dec_found;
  logic [DW-1:0]     rd_mux;
  logic              wr_fall, rd_fall;
  logic              do_wr, do_rd, set_perr;

  // Soft-reset constants are untyped so an override of the wrong width is caught here.
  if (SRST_LEN < 1 || AW <= DW || NCH < 1 ||
      $bits(SRST_ADR) != AW || $bits(SRST_KEY) != DW) begin : g_param_check
    $error("avr_bus_bridge: inconsistent parameters");
  end

  // Two-stage synchronisers for every AVR pin, plus an extra delay on the strobes for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ale_m <= 1'b0; ale_s <= 1'b0;
      wd_m  <= 1'b0; wd_s  <= 1'b0; wd_d <= 1'b0;
      rd_m  <= 1'b0; rd_s  <= 1'b0; rd_d <= 1'b0;
      ad_m  <= '0;   ad_s  <= '0;
      a_m   <= '0;   a_s   <= '0;
    end else begin
      ale_m <= ale;  ale_s <= ale_m;
      wd_m  <= wd;   wd_s  <= wd_m;  wd_d <= wd_s;
      rd_m  <= rd;   rd_s  <= rd_m;  rd_d <= rd_s;
      ad_m  <= ad;   ad_s  <= ad_m;
      a_m   <= a;    a_s   <= a_m;
    end
  end

  // Window decode of the latched address; the lowest matching channel index wins.
  always_comb begin
    sel_c     = '0;
    dec_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!dec_found && ((bus_adr & CH_MASK[i*AW +: AW]) == CH_BASE[i*AW +: AW])) begin
        sel_c[i]  = 1'b1;
        dec_found = 1'b1;
      end
    end
  end

  // Address latch follows ale; the decode result is registered one cycle behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_adr <= '0;
      sel     <= '0;
      hit     <= 1'b0;
    end else begin
      if (ale_s) bus_adr <= {a_s, ad_s};
      sel <= sel_c;
      hit <= |sel_c;
    end
  end

  // Read-data mux over the selected channel, falling back to the default byte.
  always_comb begin
    rd_mux = DEF_RD;
    for (int i = 0; i < NCH; i++) begin
      if (sel[i]) rd_mux = ch_rdata[i*DW +: DW];
    end
  end

  assign wr_fall = ~wd_s & wd_d;
  assign rd_fall = ~rd_s & rd_d;

  // Bus-cycle FSM: strobe edges are only accepted in IDLE, and a write beats a simultaneous read.
  always_comb begin
    state_next = state;
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    set_perr   = 1'b0;
    case (state)
      IDLE: begin
        if (ale_s) begin
          state_next = ADR;
        end else if (wr_fall) begin
          state_next = WR;
          do_wr      = 1'b1;
          set_perr   = ~rd_s;
        end else if (rd_fall) begin
          if (!wd_s) begin
            set_perr = 1'b1;
          end else begin
            state_next = RD;
            do_rd      = 1'b1;
          end
        end
      end
      ADR:     if (!ale_s) state_next = IDLE;
      WR:      state_next = WHOLD;
      WHOLD:   if (wd_s) state_next = IDLE;
      RD:      state_next = RHOLD;
      RHOLD:   if (rd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus the registered strobes, write data, read data and sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      d         <= DEF_RD;
      bus_wdata <= '0;
      ch_wr     <= '0;
      ch_rd     <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;
      ch_wr <= do_wr ? (sel & {NCH{hit}}) : '0;
      ch_rd <= do_rd ? (sel & {NCH{hit}}) : '0;
      if (do_wr) bus_wdata <= ad_s;
      if (do_rd) d <= hit ? rd_mux : DEF_RD;
      if (set_perr) proto_err <= 1'b1;
    end
  end

  assign oen = ~(~rd & hit & (state != ADR));

`ifdef SOFT_RESET_EN
  localparam int SCW = $clog2(SRST_LEN + 1);

  logic [SCW-1:0] srst_cnt;

  // Keyed write to the soft-reset address (re)loads the pulse counter, which then counts down.
  always_ff @(posedge clk) begin
    if (reset) begin
      srst_cnt <= '0;
    end else if (do_wr && (bus_adr == AW'(SRST_ADR)) && (ad_s == DW'(SRST_KEY))) begin
      srst_cnt <= SCW'(SRST_LEN);
    end else if (srst_cnt != '0) begin
      srst_cnt <= srst_cnt - 1'b1;
    end
  end

  assign soft_rst = (srst_cnt != '0);
`else
  assign soft_rst = 1'b0;
`endif

endmodule

// File: tb/tb_avr_bus_bridge.sv
// tb_avr_bus_bridge: directed bench for the AVR bus bridge with hand-computed expectations.
module tb_avr_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ad;
  logic [7:0]  a;
  logic        ale, wd, rd;
  logic [7:0]  d;
  logic        oen;
  logic [15:0] bus_adr;
  logic [7:0]  bus_wdata;
  logic [3:0]  ch_wr, ch_rd;
  logic [31:0] ch_rdata;
  logic        proto_err, soft_rst;

  int total_checks = 0;
  int bad_checks   = 0;
  int wr_pulses    = 0;
  int rd_pulses    = 0;
  int strobe_viol  = 0;
  int high_count;
  logic [3:0] prev_wr = '0;
  logic [3:0] prev_rd = '0;

  avr_bus_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .ad        (ad),
    .a         (a),
    .ale       (ale),
    .wd        (wd),
    .rd        (rd),
    .d         (d),
    .oen       (oen),
    .bus_adr   (bus_adr),
    .bus_wdata (bus_wdata),
    .ch_wr     (ch_wr),
    .ch_rd     (ch_rd),
    .ch_rdata  (ch_rdata),
    .proto_err (proto_err),
    .soft_rst  (soft_rst)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts pulses and flags back-to-back or multi-bit strobes.
  always @(negedge clk) begin
    if (ch_wr != 4'b0) wr_pulses++;
    if (ch_rd != 4'b0) rd_pulses++;
    if ((ch_wr != 4'b0 && prev_wr != 4'b0) || $countones(ch_wr) > 1) strobe_viol++;
    if ((ch_rd != 4'b0 && prev_rd != 4'b0) || $countones(ch_rd) > 1) strobe_viol++;
    prev_wr = ch_wr;
    prev_rd = ch_rd;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Address phase: hold ale long enough to latch, then let the FSM return to IDLE.
  task applyStimulus(input logic [15:0] addr);
    a   = addr[15:8];
    ad  = addr[7:0];
    ale = 1'b1;
    tick(3);
    ale = 1'b0;
    tick(4);
  endtask

  task writeStrobe(input string tag, input logic [7:0] data, input logic [3:0] exp_wr);
    ad = data;
    wd = 1'b0;
    tick(2);
    checkOutput({tag, "_wr_early"}, 32'(ch_wr), 32'h0);
    tick(1);
    checkOutput({tag, "_wr"}, 32'(ch_wr), 32'(exp_wr));
    checkOutput({tag, "_wdata"}, 32'(bus_wdata), 32'(data));
  endtask

  task writeRelease(input string tag);
    tick(1);
    checkOutput({tag, "_wr_drop"}, 32'(ch_wr), 32'h0);
    wd = 1'b1;
    tick(4);
  endtask

  task readCycle(input string tag, input logic [3:0] exp_rd, input logic [7:0] exp_d,
                 input logic exp_oen, input logic [7:0] prev_d);
    rd = 1'b0;
    #1;
    checkOutput({tag, "_oen_low"}, 32'(oen), 32'(exp_oen));
    tick(2);
    checkOutput({tag, "_rd_early"}, 32'(ch_rd), 32'h0);
    checkOutput({tag, "_d_early"}, 32'(d), 32'(prev_d));
    tick(1);
    checkOutput({tag, "_rd"}, 32'(ch_rd), 32'(exp_rd));
    checkOutput({tag, "_d"}, 32'(d), 32'(exp_d));
    tick(1);
    checkOutput({tag, "_rd_drop"}, 32'(ch_rd), 32'h0);
    rd = 1'b1;
    #1;
    checkOutput({tag, "_oen_rel"}, 32'(oen), 32'h1);
    tick(4);
  endtask

  initial begin
    reset    = 1'b1;
    ad       = 8'h00;
    a        = 8'h00;
    ale      = 1'b0;
    wd       = 1'b1;
    rd       = 1'b1;
    ch_rdata = {8'hA5, 8'h33, 8'h22, 8'h11};
    tick(3);
    reset = 1'b0;
    tick(1);

    $display("[TB] reset state");
    checkOutput("rst_d", 32'(d), 32'h7B);
    checkOutput("rst_oen", 32'(oen), 32'h1);
    checkOutput("rst_adr", 32'(bus_adr), 32'h0);
    checkOutput("rst_wdata", 32'(bus_wdata), 32'h0);
    checkOutput("rst_wr", 32'(ch_wr), 32'h0);
    checkOutput("rst_rd", 32'(ch_rd), 32'h0);
    checkOutput("rst_perr", 32'(proto_err), 32'h0);
    checkOutput("rst_srst", 32'(soft_rst), 32'h0);

    $display("[TB] write 0xF000 <= 0x3C");
    applyStimulus(16'hF000);
    checkOutput("t1_adr", 32'(bus_adr), 32'hF000);
    writeStrobe("t1", 8'h3C, 4'b0001);
    writeRelease("t1");

    $display("[TB] unmapped write 0x8000");
    applyStimulus(16'h8000);
    writeStrobe("unm", 8'h99, 4'b0000);
    writeRelease("unm");

    $display("[TB] read 0x4123 (channel 3)");
    applyStimulus(16'h4123);
    readCycle("t2", 4'b1000, 8'hA5, 1'b0, 8'h7B);

    $display("[TB] read 0x8000 (no hit)");
    applyStimulus(16'h8000);
    readCycle("t3", 4'b0000, 8'h7B, 1'b1, 8'hA5);

    $display("[TB] read 0xF005 (channel 0)");
    applyStimulus(16'hF005);
    readCycle("ch0", 4'b0001, 8'h11, 1'b0, 8'h7B);

    $display("[TB] wd and rd together at 0xF040");
    applyStimulus(16'hF040);
    checkOutput("t4_perr_pre", 32'(proto_err), 32'h0);
    ad = 8'h77;
    wd = 1'b0;
    rd = 1'b0;
    tick(3);
    checkOutput("t4_wr", 32'(ch_wr), 32'h4);
    checkOutput("t4_rd", 32'(ch_rd), 32'h0);
    checkOutput("t4_perr", 32'(proto_err), 32'h1);
    checkOutput("t4_wdata", 32'(bus_wdata), 32'h77);
    tick(3);
    checkOutput("t4_rd_late", 32'(ch_rd), 32'h0);
    checkOutput("t4_d_kept", 32'(d), 32'h11);
    wd = 1'b1;
    rd = 1'b1;
    tick(5);
    checkOutput("t4_perr_sticky", 32'(proto_err), 32'h1);

    $display("[TB] reset while wd held low");
    applyStimulus(16'hF000);
    ad = 8'h55;
    wd = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    checkOutput("t5_wr_rst", 32'(ch_wr), 32'h0);
    checkOutput("t5_perr_rst", 32'(proto_err), 32'h0);
    checkOutput("t5_adr_rst", 32'(bus_adr), 32'h0);
    reset = 1'b0;
    high_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (ch_wr != 4'b0) high_count++;
      tick(1);
    end
    checkOutput("t5_no_strobe", 32'(high_count), 32'h0);
    wd = 1'b1;
    tick(4);
    applyStimulus(16'hF000);
    writeStrobe("t5", 8'h66, 4'b0001);
    writeRelease("t5");

    $display("[TB] soft-reset key write to 0xF001");
    applyStimulus(16'hF001);
    writeStrobe("t6key", 8'h5A, 4'b0001);
    high_count = 0;
    for (int i = 0; i < 40; i++) begin
      if (soft_rst) high_count++;
      tick(1);
    end
`ifdef SOFT_RESET_EN
    checkOutput("t6_pulse_len", 32'(high_count), 32'd16);
`else
    checkOutput("t6_pulse_len", 32'(high_count), 32'd0);
`endif
    writeRelease("t6key");

    $display("[TB] non-key write to 0xF001");
    applyStimulus(16'hF001);
    writeStrobe("t6nokey", 8'h00, 4'b0001);
    high_count = 0;
    for (int i = 0; i < 30; i++) begin
      if (soft_rst) high_count++;
      tick(1);
    end
    checkOutput("t6_no_pulse", 32'(high_count), 32'd0);
    writeRelease("t6nokey");

    checkOutput("wr_pulse_count", 32'(wr_pulses), 32'd5);
    checkOutput("rd_pulse_count", 32'(rd_pulses), 32'd2);
    checkOutput("strobe_shape", 32'(strobe_viol), 32'd0);
    checkOutput("final_perr", 32'(proto_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
